// File: rtl/embed_lookup_int8_if.sv
// Request/result bundle for embed_lookup_int8.
//   start    : single-cycle lookup request
//   token_id : token row index, sampled with start
//   pos      : position row index, sampled with start
//   out_vec  : packed int8 result, element j at [j*8 +: 8]
//   done     : one-cycle pulse when the full vector is written
//   err      : sticky out-of-range flag, cleared by the next start
// master drives the request; slave is the lookup block.
interface embed_lookup_int8_if #(
  parameter int unsigned DIM     = 128,
  parameter int unsigned VOCAB   = 256,
  parameter int unsigned MAX_POS = 64
) ();
  localparam int unsigned TokW = $clog2(VOCAB);
  localparam int unsigned PosW = $clog2(MAX_POS);

  logic               start;
  logic [TokW-1:0]    token_id;
  logic [PosW-1:0]    pos;
  logic [DIM*8-1:0]   out_vec;
  logic               done;
  logic               err;

  modport master (
    output start, token_id, pos,
    input  out_vec, done, err
  );

  modport slave (
    input  start, token_id, pos,
    output out_vec, done, err
  );
endinterface

// File: rtl/embed_lookup_int8.sv
// Token + position embedding lookup with int8 saturating add.
// Reads one DIM-wide row from each external 1-cycle-latency ROM, adds
// element pairs with saturation and packs them into bus.out_vec.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   bus (slave)            : start/token_id/pos request, out_vec/done/err result
//   tok_addr_o, tok_data_i : token ROM address (registered) and read data
//   pos_addr_o, pos_data_i : position ROM address (registered) and read data
module embed_lookup_int8 #(
  parameter int unsigned DIM     = 128,
  parameter int unsigned VOCAB   = 256,
  parameter int unsigned MAX_POS = 64
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  embed_lookup_int8_if.slave                bus,
  output logic [$clog2(VOCAB*DIM)-1:0]      tok_addr_o,
  input  logic signed [7:0]                 tok_data_i,
  output logic [$clog2(MAX_POS*DIM)-1:0]    pos_addr_o,
  input  logic signed [7:0]                 pos_data_i
);
  localparam int unsigned TokW  = $clog2(VOCAB);
  localparam int unsigned PosW  = $clog2(MAX_POS);
  localparam int unsigned TokAw = $clog2(VOCAB*DIM);
  localparam int unsigned PosAw = $clog2(MAX_POS*DIM);
  localparam int unsigned ColW  = (DIM > 1) ? $clog2(DIM) : 1;

  typedef enum logic [1:0] {StIdle, StPrefetch, StRun} state_e;

  state_e           state_q;
  logic [ColW-1:0]  col_q;
  logic [TokAw-1:0] tok_addr_q;
  logic [PosAw-1:0] pos_addr_q;
  logic [DIM*8-1:0] out_vec_q;
  logic             done_q;
  logic             err_q;

  // Range check and base addresses for a new request.
  logic             tok_bad, pos_bad;
  logic [TokW-1:0]  tok_sel;
  logic [PosW-1:0]  pos_sel;
  logic [TokAw-1:0] tok_base;
  logic [PosAw-1:0] pos_base;

  always_comb begin
    tok_bad  = 32'(bus.token_id) >= VOCAB;
    pos_bad  = 32'(bus.pos) >= MAX_POS;
    tok_sel  = tok_bad ? '0 : bus.token_id;
    pos_sel  = pos_bad ? '0 : bus.pos;
    tok_base = TokAw'(32'(tok_sel) * DIM);
    pos_base = PosAw'(32'(pos_sel) * DIM);
  end

  // 9-bit sum cannot overflow; the top two bits disagree exactly when
  // the result leaves the int8 range.
  logic signed [8:0] sum;
  logic        [7:0] sat;

  always_comb begin
    sum = {tok_data_i[7], tok_data_i} + {pos_data_i[7], pos_data_i};
    unique case (sum[8:7])
      2'b01:   sat = 8'h7f;
      2'b10:   sat = 8'h80;
      default: sat = sum[7:0];
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      col_q      <= '0;
      tok_addr_q <= '0;
      pos_addr_q <= '0;
      out_vec_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else if (bus.start) begin
      // A start wins in every state, including the last RUN cycle.
      state_q    <= StPrefetch;
      col_q      <= '0;
      tok_addr_q <= tok_base;
      pos_addr_q <= pos_base;
      done_q     <= 1'b0;
      err_q      <= tok_bad | pos_bad;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
        end
        StPrefetch: begin
          tok_addr_q <= tok_addr_q + 1'b1;
          pos_addr_q <= pos_addr_q + 1'b1;
          state_q    <= StRun;
        end
        StRun: begin
          out_vec_q[{col_q, 3'b000} +: 8] <= sat;
          if (col_q == ColW'(DIM - 1)) begin
            // Addresses park at base+DIM: a harmless one-word over-read.
            col_q   <= '0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            col_q      <= col_q + 1'b1;
            tok_addr_q <= tok_addr_q + 1'b1;
            pos_addr_q <= pos_addr_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign tok_addr_o  = tok_addr_q;
  assign pos_addr_o  = pos_addr_q;
  assign bus.out_vec = out_vec_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule
